// File: rtl/uart_bus_pkg.sv
// Shared register map, STATUS/CTRL bit positions and shifter states for uart_bus_fifo.
// Also holds the divisor floor so that TX and RX clamp the divisor the same way.
package uart_bus_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DIVLO  = 3'd3;
    localparam logic [2:0] REG_DIVHI  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam int         NUM_REGS   = 8;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_BUSY  = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_FRM_ERR  = 6;
    localparam int STAT_TX_OVF   = 7;

    localparam int CTRL_RX_IEN = 0;
    localparam int CTRL_TX_IEN = 1;
    localparam int CTRL_FLUSH  = 6;
    localparam int CTRL_CLR    = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd4) ? 16'd4 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data; push+pop in one cycle always both succeed.
// Flush empties the FIFO and wins over a same-cycle push; full drops pushes unless popping.
module sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [DSIZE-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [DSIZE-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (ASIZE+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & (~o_full | i_pop) & ~i_flush;
    assign w_do_pop  = i_pop & (~o_empty | i_push);
    // An empty FIFO popped while being pushed hands the incoming word straight through.
    assign o_pop_dat = o_empty ? i_push_dat : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (ASIZE+1)'(w_do_push) - (ASIZE+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/uart_bus_fifo.sv
// Bus-mapped UART with TX/RX FIFOs; registered reads (1 cycle), full FIFOs drop and flag overflow.
// Define UART_PARITY_EN for 8E1 framing; default build is 8N1. Bus accesses decode only inside the 8-register window.
module uart_bus_fifo
    import uart_bus_pkg::*;
#(
    parameter logic [15:0] BaseAddress     = 16'h0000,
    parameter logic [15:0] Address_Wording = 16'd1,
    parameter logic [15:0] DefaultDivisor  = 16'd434,
    parameter int          FifoDepthLog2   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] address_i,
    input  logic [7:0]  data_i,
    input  logic        rd_wr_i,
    output logic [7:0]  data_o,
    output logic        irq_o,
    input  logic        rx_i,
    output logic        tx_o
);

    logic [15:0] w_off;
    logic        w_hit;
    logic [2:0]  w_reg;
    logic        w_wr, w_rd, w_wr_tx, w_rd_rx, w_wr_ctrl, w_flush, w_clr;
    logic [15:0] r_div;
    logic        r_rx_ien, r_tx_ien;
    logic        r_tx_ovf, r_rx_ovf, r_frm_err;
    logic [7:0]  r_dout;
    logic        r_irq;
    logic [7:0]  w_status;

    logic        w_tx_full, w_tx_empty, w_tx_pop;
    logic [7:0]  w_tx_dat;
    logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_err;
    logic [7:0]  w_rx_rdat;

    assign w_off = address_i - BaseAddress;

    always_comb begin
        w_hit = 1'b0;
        w_reg = 3'd0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_off == 16'(k) * Address_Wording) begin
                w_hit = 1'b1;
                w_reg = 3'(k);
            end
        end
    end

    assign w_wr      = w_hit & rd_wr_i;
    assign w_rd      = w_hit & ~rd_wr_i;
    assign w_wr_tx   = w_wr & (w_reg == REG_TXDATA);
    assign w_rd_rx   = w_rd & (w_reg == REG_RXDATA);
    assign w_wr_ctrl = w_wr & (w_reg == REG_CTRL);
    assign w_flush   = w_wr_ctrl & data_i[CTRL_FLUSH];
    assign w_clr     = w_wr_ctrl & data_i[CTRL_CLR];

    sync_fifo #(.DSIZE(8), .ASIZE(FifoDepthLog2)) u_tx_fifo (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_push     (w_wr_tx),
        .i_push_dat (data_i),
        .i_pop      (w_tx_pop),
        .i_flush    (w_flush),
        .o_pop_dat  (w_tx_dat),
        .o_full     (w_tx_full),
        .o_empty    (w_tx_empty)
    );

    // ---------------- transmitter ----------------
    uart_state_e r_tx_state, w_tx_nxt;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        r_tx, w_tx_line, w_tx_end;
`ifdef UART_PARITY_EN
    logic        r_tx_par;
`endif

    assign w_tx_end = (r_tx_cnt == r_tx_div - 16'd1);

    always_comb begin
        w_tx_nxt  = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_line = r_tx;
        case (r_tx_state)
            S_IDLE: if (!w_tx_empty) begin
                w_tx_pop  = 1'b1;
                w_tx_nxt  = S_START;
                w_tx_line = 1'b0;
            end
            S_START: if (w_tx_end) begin
                w_tx_nxt  = S_DATA;
                w_tx_line = r_tx_shift[0];
            end
            S_DATA: if (w_tx_end) begin
                if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    w_tx_nxt  = S_PARITY;
                    w_tx_line = r_tx_par;
`else
                    w_tx_nxt  = S_STOP;
                    w_tx_line = 1'b1;
`endif
                end else begin
                    w_tx_line = r_tx_shift[1];
                end
            end
            S_PARITY: if (w_tx_end) begin
                w_tx_nxt  = S_STOP;
                w_tx_line = 1'b1;
            end
            S_STOP: if (w_tx_end) begin
                // Chain straight into the next start bit when more data is queued.
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_nxt  = S_START;
                    w_tx_line = 1'b0;
                end else begin
                    w_tx_nxt  = S_IDLE;
                    w_tx_line = 1'b1;
                end
            end
            default: begin
                w_tx_nxt  = S_IDLE;
                w_tx_line = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= 16'd4;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            r_tx_state <= w_tx_nxt;
            r_tx       <= w_tx_line;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_dat;
                r_tx_div   <= eff_div(r_div);
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                r_tx_par   <= ^w_tx_dat;
`endif
            end else if (r_tx_state != S_IDLE) begin
                if (w_tx_end) begin
                    r_tx_cnt <= '0;
                    if (r_tx_state == S_DATA) begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 3'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    uart_state_e r_rx_state, w_rx_nxt;
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;
    logic        r_rx_s1, r_rx_s2, r_rx_d;
    logic        w_rx_start, w_rx_half, w_rx_end;
`ifdef UART_PARITY_EN
    logic        r_rx_par_err;
`endif

    assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
    assign w_rx_end  = (r_rx_cnt == r_rx_div - 16'd1);

    always_comb begin
        w_rx_nxt   = r_rx_state;
        w_rx_start = 1'b0;
        w_rx_push  = 1'b0;
        w_rx_err   = 1'b0;
        case (r_rx_state)
            S_IDLE: if (!r_rx_s2 && r_rx_d) begin
                w_rx_start = 1'b1;
                w_rx_nxt   = S_START;
            end
            S_START: if (w_rx_half) begin
                w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_end && r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                w_rx_nxt = S_PARITY;
`else
                w_rx_nxt = S_STOP;
`endif
            end
            S_PARITY: if (w_rx_end) begin
                w_rx_nxt = S_STOP;
            end
            S_STOP: if (w_rx_end) begin
                w_rx_nxt  = S_IDLE;
                w_rx_push = 1'b1;
`ifdef UART_PARITY_EN
                w_rx_err  = ~r_rx_s2 | r_rx_par_err;
`else
                w_rx_err  = ~r_rx_s2;
`endif
            end
            default: w_rx_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_div   <= 16'd4;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_rx_par_err <= 1'b0;
`endif
        end else begin
            r_rx_s1    <= rx_i;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_nxt;
            if (w_rx_start) begin
                r_rx_div <= eff_div(r_div);
                r_rx_cnt <= '0;
                r_rx_bit <= '0;
`ifdef UART_PARITY_EN
                r_rx_par_err <= 1'b0;
`endif
            end else if (r_rx_state == S_START) begin
                r_rx_cnt <= w_rx_half ? 16'd0 : r_rx_cnt + 16'd1;
            end else if (r_rx_state != S_IDLE) begin
                if (w_rx_end) begin
                    r_rx_cnt <= '0;
                    if (r_rx_state == S_DATA) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end
`ifdef UART_PARITY_EN
                    if (r_rx_state == S_PARITY) begin
                        r_rx_par_err <= r_rx_s2 ^ (^r_rx_shift);
                    end
`endif
                end else begin
                    r_rx_cnt <= r_rx_cnt + 16'd1;
                end
            end
        end
    end

    sync_fifo #(.DSIZE(8), .ASIZE(FifoDepthLog2)) u_rx_fifo (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_push     (w_rx_push),
        .i_push_dat (r_rx_shift),
        .i_pop      (w_rd_rx),
        .i_flush    (w_flush),
        .o_pop_dat  (w_rx_rdat),
        .o_full     (w_rx_full),
        .o_empty    (w_rx_empty)
    );

    // ---------------- registers, flags, read path ----------------
    always_comb begin
        w_status                = '0;
        w_status[STAT_TX_FULL]  = w_tx_full;
        w_status[STAT_TX_EMPTY] = w_tx_empty;
        w_status[STAT_RX_EMPTY] = w_rx_empty;
        w_status[STAT_RX_FULL]  = w_rx_full;
        w_status[STAT_TX_BUSY]  = (r_tx_state != S_IDLE);
        w_status[STAT_RX_OVF]   = r_rx_ovf;
        w_status[STAT_FRM_ERR]  = r_frm_err;
        w_status[STAT_TX_OVF]   = r_tx_ovf;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_div     <= DefaultDivisor;
            r_rx_ien  <= 1'b0;
            r_tx_ien  <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_frm_err <= 1'b0;
            r_dout    <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && w_reg == REG_DIVLO) r_div[7:0]  <= data_i;
            if (w_wr && w_reg == REG_DIVHI) r_div[15:8] <= data_i;
            if (w_wr_ctrl) begin
                r_rx_ien <= data_i[CTRL_RX_IEN];
                r_tx_ien <= data_i[CTRL_TX_IEN];
            end
            // A flag being set in the same cycle as a clear stays set.
            r_tx_ovf  <= (r_tx_ovf & ~w_clr) | (w_wr_tx & w_tx_full & ~w_tx_pop & ~w_flush);
            r_rx_ovf  <= (r_rx_ovf & ~w_clr) | (w_rx_push & w_rx_full & ~w_rd_rx & ~w_flush);
            r_frm_err <= (r_frm_err & ~w_clr) | w_rx_err;
            if (w_rd) begin
                case (w_reg)
                    REG_RXDATA: r_dout <= (w_rx_empty && !w_rx_push) ? 8'h00 : w_rx_rdat;
                    REG_STATUS: r_dout <= w_status;
                    REG_DIVLO:  r_dout <= r_div[7:0];
                    REG_DIVHI:  r_dout <= r_div[15:8];
                    REG_CTRL:   r_dout <= {6'b0, r_tx_ien, r_rx_ien};
                    default:    r_dout <= 8'h00;
                endcase
            end
            r_irq <= (r_rx_ien & ~w_rx_empty) | (r_tx_ien & w_tx_empty & (r_tx_state == S_IDLE));
        end
    end

    assign data_o = r_dout;
    assign irq_o  = r_irq;
    assign tx_o   = r_tx;

endmodule

// File: tb/tb_uart_bus_fifo.sv
// Directed bench for uart_bus_fifo (8N1, 4-deep FIFOs): register map, TX timing, loopback, overflow, errors, irq.
module tb_uart_bus_fifo;

    localparam logic [15:0] A_TX   = 16'd0;
    localparam logic [15:0] A_RX   = 16'd1;
    localparam logic [15:0] A_ST   = 16'd2;
    localparam logic [15:0] A_DL   = 16'd3;
    localparam logic [15:0] A_DH   = 16'd4;
    localparam logic [15:0] A_CT   = 16'd5;
    localparam logic [15:0] A_UNM  = 16'd6;
    localparam logic [15:0] A_IDLE = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = A_IDLE;
    logic [7:0]  data_in = 8'h00;
    logic        rd_wr = 1'b0;
    logic [7:0]  data_out;
    logic        irq;
    logic        tx;
    logic        rx_line;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_bus_fifo #(
        .BaseAddress     (16'h0000),
        .Address_Wording (16'd1),
        .DefaultDivisor  (16'd434),
        .FifoDepthLog2   (2)
    ) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .address_i (address),
        .data_i    (data_in),
        .rd_wr_i   (rd_wr),
        .data_o    (data_out),
        .irq_o     (irq),
        .rx_i      (rx_line),
        .tx_o      (tx)
    );

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; rd_wr = 1'b1;
        @(negedge clk);
        address = A_IDLE; data_in = 8'h00; rd_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a; rd_wr = 1'b0;
        @(negedge clk);
        d = data_out;
        address = A_IDLE;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(negedge clk);
        end
        rx_drv = stop;
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] addrs [5];
        logic [7:0]  exps  [5];
        logic [7:0]  d;
        addrs = '{A_DL, A_DH, A_ST, A_CT, A_UNM};
        exps  = '{8'hB2, 8'h01, 8'h06, 8'h00, 8'h00};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_o: got %02h expected 00", data_out); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rd(addrs[i], d);
            n_cmp++;
            if (d !== exps[i]) begin
                n_bad++; $display("FAIL reset_reg[%0d]: got %02h expected %02h", addrs[i], d, exps[i]);
            end
        end
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        logic       exp;
        int         slot;
        logic [7:0] byte_v;
        byte_v = 8'h55;
        bus_wr(A_DH, 8'h00);
        bus_wr(A_DL, 8'h08);
        bus_wr(A_TX, byte_v);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_pre_start: got %b expected 1", tx); end
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            slot = c / 8;
            if (slot == 0)      exp = 1'b0;
            else if (slot <= 8) exp = byte_v[slot-1];
            else                exp = 1'b1;
            n_cmp++;
            if (tx !== exp) begin n_bad++; $display("FAIL tx_bit cycle %0d: got %b expected %b", c, tx, exp); end
        end
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL tx_done_status: got %02h expected 06", d); end
    endtask

    task automatic test_loopback();
        logic [7:0] d;
        loop_en = 1'b1;
        bus_wr(A_TX, 8'hA3);
        bus_wr(A_TX, 8'h0F);
        repeat (200) @(negedge clk);
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'hA3) begin n_bad++; $display("FAIL loop_rx0: got %02h expected a3", d); end
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'h0F) begin n_bad++; $display("FAIL loop_rx1: got %02h expected 0f", d); end
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL loop_status: got %02h expected 06", d); end
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL loop_rx_empty_read: got %02h expected 00", d); end
        loop_en = 1'b0;
    endtask

    task automatic test_div_clamp();
        logic [7:0] d;
        logic       exp;
        bus_wr(A_DL, 8'h00);
        bus_wr(A_TX, 8'hFE);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            exp = (c < 8) ? 1'b0 : 1'b1;
            n_cmp++;
            if (tx !== exp) begin n_bad++; $display("FAIL clamp_bit cycle %0d: got %b expected %b", c, tx, exp); end
        end
        repeat (40) @(negedge clk);
        bus_rd(A_DL, d);
        n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL clamp_divlo: got %02h expected 00", d); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] d;
        bus_wr(A_DH, 8'hFF);
        bus_wr(A_TX, 8'h00);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) bus_wr(A_TX, 8'h10 + 8'(i));
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h95) begin n_bad++; $display("FAIL txovf_status: got %02h expected 95", d); end
        bus_wr(A_CT, 8'h80);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h15) begin n_bad++; $display("FAIL txovf_cleared: got %02h expected 15", d); end
        bus_wr(A_CT, 8'h40);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h16) begin n_bad++; $display("FAIL txovf_flushed: got %02h expected 16", d); end
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
        @(negedge clk);
        rst = 1'b0;
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL post_reset_status: got %02h expected 06", d); end
        bus_rd(A_DL, d);
        n_cmp++; if (d !== 8'hB2) begin n_bad++; $display("FAIL post_reset_divlo: got %02h expected b2", d); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d;
        bus_wr(A_DH, 8'h00);
        bus_wr(A_DL, 8'h08);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h55, 1'b1);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h2A) begin n_bad++; $display("FAIL rxovf_status: got %02h expected 2a", d); end
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL rxovf_first: got %02h expected 11", d); end
        bus_wr(A_CT, 8'hC0);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL rx_flush_clear: got %02h expected 06", d); end
        send_frame(8'h5A, 1'b0);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h42) begin n_bad++; $display("FAIL frame_err_status: got %02h expected 42", d); end
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL frame_err_byte: got %02h expected 5a", d); end
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h46) begin n_bad++; $display("FAIL frame_err_sticky: got %02h expected 46", d); end
        bus_wr(A_CT, 8'h80);
        bus_rd(A_ST, d);
        n_cmp++; if (d !== 8'h06) begin n_bad++; $display("FAIL frame_err_cleared: got %02h expected 06", d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_wr(A_CT, 8'h01);
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_idle: got %b expected 0", irq); end
        send_frame(8'h3C, 1'b1);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rx: got %b expected 1", irq); end
        bus_rd(A_RX, d);
        n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL irq_rx_byte: got %02h expected 3c", d); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_rx_cleared: got %b expected 0", irq); end
        bus_wr(A_CT, 8'h02);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
        bus_wr(A_CT, 8'h00);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_div_clamp();
        test_tx_overflow();
        test_rx_overflow();
        test_irq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
